modulo_interfaz: RTL and testbench

MODULO_INTERFAZ -- requirements
Module: modulo_interfaz

---
 rtl/modulo_interfaz.sv | 94 +++++++++
 tb/tb_modulo_interfaz.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_interfaz.sv
// Byte-serial front end for modulo_alu: collects operand A, operand B and the opcode
// from the UART receiver, latches the ALU result and hands it to the UART transmitter.
module modulo_interfaz #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] rx_dato,
    input  logic              rx_done,
    input  logic [N_BITS-1:0] resultado,
    input  logic              tx_done,
    output logic [N_BITS-1:0] nr1,
    output logic [N_BITS-1:0] nr2,
    output logic [N_OP-1:0]   operacion,
    output logic [N_BITS-1:0] tx_dato,
    output logic              tx_start,
    output logic              ocupado,
    output logic              descartado
);

    typedef enum logic [2:0] {
        ESPERA_NR1,
        ESPERA_NR2,
        ESPERA_OP,
        CALCULO,
        ESPERA_TX
    } estado_t;

    estado_t estado, estado_sig;
    logic    carga_nr1, carga_nr2, carga_op, carga_tx, descarta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= ESPERA_NR1;
        else       estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        carga_nr1  = 1'b0;
        carga_nr2  = 1'b0;
        carga_op   = 1'b0;
        carga_tx   = 1'b0;
        descarta   = 1'b0;
        ocupado    = 1'b0;
        case (estado)
            ESPERA_NR1: if (rx_done) begin
                carga_nr1  = 1'b1;
                estado_sig = ESPERA_NR2;
            end
            ESPERA_NR2: if (rx_done) begin
                carga_nr2  = 1'b1;
                estado_sig = ESPERA_OP;
            end
            ESPERA_OP: if (rx_done) begin
                carga_op   = 1'b1;
                estado_sig = CALCULO;
            end
            CALCULO: begin
                // modulo_alu is combinational, so the result is already settled here
                carga_tx   = 1'b1;
                descarta   = rx_done;
                ocupado    = 1'b1;
                estado_sig = ESPERA_TX;
            end
            ESPERA_TX: begin
                descarta = rx_done;
                ocupado  = 1'b1;
                if (tx_done) estado_sig = ESPERA_NR1;
            end
            default: estado_sig = ESPERA_NR1;
        endcase
    end

    // Operand/opcode/result registers keep their value until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nr1        <= '0;
            nr2        <= '0;
            operacion  <= '0;
            tx_dato    <= '0;
            tx_start   <= 1'b0;
            descartado <= 1'b0;
        end else begin
            if (carga_nr1) nr1       <= rx_dato;
            if (carga_nr2) nr2       <= rx_dato;
            if (carga_op)  operacion <= rx_dato[N_OP-1:0];
            if (carga_tx)  tx_dato   <= resultado;
            tx_start   <= carga_tx;
            descartado <= descarta;
        end
    end

endmodule

// File: tb/tb_modulo_interfaz.sv
// Scoreboard bench for modulo_interfaz: a behavioural ALU feeds resultado, a transaction
// model predicts every tx_start and descartado pulse, and a monitor checks them as they appear.
module tb_modulo_interfaz;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_dato;
    logic       rx_done;
    logic [7:0] resultado;
    logic       tx_done;
    logic [7:0] nr1, nr2, tx_dato;
    logic [5:0] operacion;
    logic       tx_start, ocupado, descartado;

    modulo_interfaz #(.N_BITS(8), .N_OP(6)) dut (
        .clk(clk), .reset(reset), .rx_dato(rx_dato), .rx_done(rx_done),
        .resultado(resultado), .tx_done(tx_done), .nr1(nr1), .nr2(nr2),
        .operacion(operacion), .tx_dato(tx_dato), .tx_start(tx_start),
        .ocupado(ocupado), .descartado(descartado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return 8'($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in for modulo_alu
    always_comb resultado = alu_ref(nr1, nr2, operacion);

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    exp_t e;
    int   dc;

    // Transaction model
    int         m_idx  = 0;
    bit         m_busy = 0;
    logic [7:0] m_a, m_b;

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_start) begin
                if (exp_q.size() == 0) check("unexpected tx_start", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tx_start cycle", cyc, e.cyc);
                    check("tx_dato", int'(tx_dato), int'(e.res));
                    check("nr1 at tx", int'(nr1), int'(e.a));
                    check("nr2 at tx", int'(nr2), int'(e.b));
                    check("operacion at tx", int'(operacion), int'(e.op));
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("tx_start missing at cycle", cyc, e.cyc);
            end
            if (descartado) begin
                if (drop_q.size() == 0) check("unexpected descartado", 1, 0);
                else begin
                    dc = drop_q.pop_front();
                    check("descartado cycle", cyc, dc);
                end
            end
            if (drop_q.size() > 0 && drop_q[0] < cyc) begin
                dc = drop_q.pop_front();
                check("descartado missing at cycle", cyc, dc);
            end
        end
    end

    task automatic model_rx(input logic [7:0] v, input int c);
        if (m_busy) drop_q.push_back(c + 1);
        else if (m_idx == 0) begin m_a = v; m_idx = 1; end
        else if (m_idx == 1) begin m_b = v; m_idx = 2; end
        else begin
            exp_q.push_back('{c + 2, alu_ref(m_a, m_b, v[5:0]), m_a, m_b, v[5:0]});
            m_idx  = 0;
            m_busy = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_dato = v;
        rx_done = 1'b1;
        model_rx(v, cyc);
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        m_busy  = 0;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic rx_and_tx_done(input logic [7:0] v);
        @(posedge clk); #1;
        rx_dato = v;
        rx_done = 1'b1;
        tx_done = 1'b1;
        model_rx(v, cyc);
        m_busy  = 0;
        @(posedge clk); #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input int gap);
        send_byte(a);
        repeat (gap) @(posedge clk);
        send_byte(b);
        repeat (gap) @(posedge clk);
        send_byte(op);
    endtask

    // Returns on the negedge where tx_start is seen, or flags a timeout.
    task automatic wait_tx();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1;
        end
        if (!seen) check("tx_start timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rst nr1", int'(nr1), 0);
        check("rst nr2", int'(nr2), 0);
        check("rst operacion", int'(operacion), 0);
        check("rst tx_dato", int'(tx_dato), 0);
        check("rst tx_start", int'(tx_start), 0);
        check("rst descartado", int'(descartado), 0);
        check("rst ocupado", int'(ocupado), 0);
        exp_q.delete();
        drop_q.delete();
        m_idx  = 0;
        m_busy = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    initial begin
        reset   = 1'b1;
        rx_dato = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Add
        txn(8'h0F, 8'h0F, 8'h20, 0);
        wait_tx();
        check("add nr1", int'(nr1), 8'h0F);
        check("add nr2", int'(nr2), 8'h0F);
        check("add operacion", int'(operacion), 8'h20);
        check("add tx_dato", int'(tx_dato), 8'h1E);
        pulse_tx_done();

        // Upper opcode bits dropped, then subtract
        txn(8'h06, 8'h02, 8'hE4, 1);
        wait_tx();
        check("and operacion", int'(operacion), 8'h24);
        check("and tx_dato", int'(tx_dato), 8'h02);
        pulse_tx_done();
        txn(8'h06, 8'h02, 8'h22, 2);
        wait_tx();
        check("sub tx_dato", int'(tx_dato), 8'h04);
        pulse_tx_done();

        // Byte during ESPERA_TX is dropped
        txn(8'h21, 8'h05, 8'h20, 0);
        wait_tx();
        send_byte(8'h55);
        check("drop nr1 held", int'(nr1), 8'h21);
        check("drop descartado", int'(descartado), 1);
        pulse_tx_done();
        send_byte(8'h77);
        check("nr1 after tx_done", int'(nr1), 8'h77);
        send_byte(8'h01);
        send_byte(8'h20);
        wait_tx();
        check("held-op tx_dato", int'(tx_dato), 8'h78);
        pulse_tx_done();

        // rx_done and tx_done together
        txn(8'h40, 8'h02, 8'h26, 0);
        wait_tx();
        rx_and_tx_done(8'h99);
        check("both ocupado", int'(ocupado), 0);
        check("both descartado", int'(descartado), 1);
        check("both nr1 held", int'(nr1), 8'h40);

        // Long wait in ESPERA_TX
        txn(8'h10, 8'h03, 8'h25, 0);
        wait_tx();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hold ocupado", int'(ocupado), 1);
            check("hold tx_start", int'(tx_start), 0);
        end
        pulse_tx_done();

        // Reset mid-sequence
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        txn(8'h03, 8'h04, 8'h20, 0);
        wait_tx();
        check("post-reset tx_dato", int'(tx_dato), 8'h07);
        check("post-reset nr1", int'(nr1), 8'h03);
        pulse_tx_done();

        // Reset in CALCULO: no tx_start may follow
        txn(8'h05, 8'h05, 8'h20, 0);
        do_reset();
        repeat (5) @(negedge clk);
        check("abandon tx_start", int'(tx_start), 0);
        check("abandon ocupado", int'(ocupado), 0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            txn(8'($urandom), 8'($urandom),
                {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]},
                $urandom_range(0, 2));
            wait_tx();
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 3) == 0) rx_and_tx_done(8'($urandom));
            else pulse_tx_done();
            // tx_done outside ESPERA_TX must do nothing
            if ($urandom_range(0, 3) == 0) pulse_tx_done();
        end

        repeat (5) @(negedge clk);
        check("pending tx_start", exp_q.size(), 0);
        check("pending descartado", drop_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
